// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer (optional CPU_SEQ_ILLEGAL_TRAP_EN)
module cpu_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int ICOUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                alu_en,
    output logic                reg_we,
    output logic                wb_sel,
    output logic                halted,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [ICOUNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ALU_LIM = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_LOAD    = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_STORE   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JUMP    = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_BEQZ    = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_NOP     = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HALT    = OPCODE_W'(15);

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   is_alu;
    logic   is_load;
    logic   is_store;
    logic   is_jump;
    logic   is_beqz;
    logic   is_nop;
    logic   is_halt;
    logic   is_illegal;

    // Opcode classification; anything not recognised is illegal (0xC, 0xD).
    always_comb begin
        is_alu     = (opcode < OP_ALU_LIM);
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_jump    = (opcode == OP_JUMP);
        is_beqz    = (opcode == OP_BEQZ);
        is_nop     = (opcode == OP_NOP);
        is_halt    = (opcode == OP_HALT);
        is_illegal = !(is_alu || is_load || is_store || is_jump || is_beqz || is_nop || is_halt);
    end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic trap;
`endif

    // Next-state and strobe decode; strobes depend only on state and live inputs.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_en   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        trap     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_nop) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_halt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (is_illegal) begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                    trap    = 1'b1;
                    state_d = S_HALT;
`else
                    retire  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (is_alu) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_jump) begin
                    pc_load = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_beqz) begin
                    pc_load = zero_flag;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    // Opcode changed under us; resynchronise on the next fetch.
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = is_load;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; async reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      icount <= '0;
        else if (retire) icount <= icount + ICOUNT_W'(1);
    end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    illegal_q <= 1'b0;
        else if (trap) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  opcode;
    logic        zero_flag;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic        alu_en, reg_we, wb_sel, halted, illegal;
    logic [2:0]  state;
    logic [15:0] icount;

    always #5 clk = ~clk;

    cpu_sequencer #(.OPCODE_W(4), .ICOUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal), .state(state), .icount(icount)
    );

    // Strobe vector order: req we asel irl pci pcl alu rwe wbs hlt
    localparam logic [9:0] REQ  = 10'h200;
    localparam logic [9:0] WE   = 10'h100;
    localparam logic [9:0] ASEL = 10'h080;
    localparam logic [9:0] IRL  = 10'h040;
    localparam logic [9:0] PCI  = 10'h020;
    localparam logic [9:0] PCL  = 10'h010;
    localparam logic [9:0] ALU  = 10'h008;
    localparam logic [9:0] RWE  = 10'h004;
    localparam logic [9:0] WBS  = 10'h002;
    localparam logic [9:0] HLT  = 10'h001;

    typedef struct packed {
        logic [2:0] st;
        logic [9:0] strb;
        logic       rdy;
        logic       zf;
        logic       ret;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_icount;
    logic [3:0]  cur_op;

    function automatic logic [9:0] strobes();
        return {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_en, reg_we, wb_sel, halted};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] st, input logic [9:0] strb, input logic rdy,
                       input logic zf, input logic ret);
        exp_t e;
        e.st = st; e.strb = strb; e.rdy = rdy; e.zf = zf; e.ret = ret;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle trace of one instruction from its class and wait counts.
    task automatic build(input logic [3:0] op, input int fw, input int mw, input logic zf);
        logic st_op;
        cur_op = op;
        st_op  = (op == 4'h9);
        for (int i = 0; i < fw; i++) add(3'd1, REQ, 1'b0, 1'($urandom), 1'b0);
        add(3'd1, REQ | IRL | PCI, 1'b1, 1'($urandom), 1'b0);
        if (op == 4'hE || op == 4'hF) begin
            add(3'd2, 10'h0, 1'($urandom), 1'($urandom), 1'b1);
        end else if (op == 4'hC || op == 4'hD) begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            add(3'd2, 10'h0, 1'($urandom), 1'($urandom), 1'b0);
`else
            add(3'd2, 10'h0, 1'($urandom), 1'($urandom), 1'b1);
`endif
        end else begin
            add(3'd2, 10'h0, 1'($urandom), 1'($urandom), 1'b0);
            if (op < 4'h8) begin
                add(3'd3, ALU, 1'($urandom), 1'($urandom), 1'b0);
                add(3'd5, RWE, 1'($urandom), 1'($urandom), 1'b1);
            end else if (op == 4'hA) begin
                add(3'd3, ALU | PCL, 1'($urandom), 1'($urandom), 1'b1);
            end else if (op == 4'hB) begin
                add(3'd3, zf ? (ALU | PCL) : ALU, 1'($urandom), zf, 1'b1);
            end else begin
                add(3'd3, ALU, 1'($urandom), 1'($urandom), 1'b0);
                for (int i = 0; i < mw; i++)
                    add(3'd4, REQ | ASEL | (st_op ? WE : 10'h0), 1'b0, 1'($urandom), 1'b0);
                add(3'd4, REQ | ASEL | (st_op ? WE : 10'h0), 1'b1, 1'($urandom), st_op);
                if (!st_op) add(3'd5, RWE | WBS, 1'($urandom), 1'($urandom), 1'b1);
            end
        end
    endtask

    // Drive each expected cycle at the falling edge and compare before the next rising edge.
    task automatic play(input int upto);
        for (int i = 0; i < q.size() && i < upto; i++) begin
            mem_ready = q[i].rdy;
            zero_flag = q[i].zf;
            opcode    = (q[i].st == 3'd1) ? 4'($urandom) : cur_op;
            run       = 1'($urandom);
            #1;
            chk("state", 32'(state), 32'(q[i].st));
            chk("strobes", 32'(strobes()), 32'(q[i].strb));
            chk("icount", 32'(icount), 32'(m_icount));
            chk("illegal", 32'(illegal), 32'd0);
            if (q[i].ret) m_icount = m_icount + 16'd1;
            @(negedge clk);
        end
        q.delete();
    endtask

    initial begin
        logic [3:0] op;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 4'h0; zero_flag = 1'b0;
        m_icount = 16'd0; cur_op = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom);
            #1;
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_strobes", 32'(strobes()), 32'd0);
            chk("idle_icount", 32'(icount), 32'd0);
            @(negedge clk);
        end
        run = 1'b1;
        #1 chk("idle_run", 32'(state), 32'd0);
        @(negedge clk);

        build(4'h3, 0, 0, 1'b0);
        chk("alu_len", 32'(q.size()), 32'd4);
        play(1000);
        chk("alu_icount_lit", 32'(icount), 32'd1);

        build(4'h8, 0, 3, 1'b0);
        chk("load_len", 32'(q.size()), 32'd8);
        play(1000);
        chk("load_icount_lit", 32'(icount), 32'd2);

        build(4'hB, 0, 0, 1'b1);
        chk("beqz1_len", 32'(q.size()), 32'd3);
        play(1000);
        build(4'hB, 0, 0, 1'b0);
        chk("beqz0_len", 32'(q.size()), 32'd3);
        play(1000);
        build(4'h9, 0, 0, 1'b0);
        chk("store_len", 32'(q.size()), 32'd4);
        play(1000);
        build(4'hE, 0, 0, 1'b0);
        chk("nop_len", 32'(q.size()), 32'd2);
        play(1000);
        chk("nop_icount_lit", 32'(icount), 32'd6);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 14));
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            if (op == 4'hC || op == 4'hD) op = 4'hE;
`endif
            build(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            play(1000);
        end

        force dut.icount = 16'hFFFE;
        #1 release dut.icount;
        m_icount = 16'hFFFE;
        build(4'hE, 1, 0, 1'b0);
        play(1000);
        chk("wrap_ffff_lit", 32'(icount), 32'hFFFF);
        build(4'h2, 0, 0, 1'b0);
        play(1000);
        chk("wrap_zero_lit", 32'(icount), 32'h0);

        build(4'hC, 0, 0, 1'b0);
        play(1000);
        mem_ready = 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        #1;
        chk("trap_state", 32'(state), 32'd6);
        chk("trap_illegal", 32'(illegal), 32'd1);
        chk("trap_icount", 32'(icount), 32'h0);
        rst_n = 1'b0;
        #1 chk("trap_cleared", 32'(illegal), 32'd0);
        m_icount = 16'd0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);
`else
        chk("illegal_nop_icount", 32'(icount), 32'h1);
`endif

        build(4'h9, 0, 5, 1'b0);
        play(5);
        mem_ready = 1'b0;
        #1;
        chk("midmem_req", 32'(mem_req), 32'd1);
        chk("midmem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_icount", 32'(icount), 32'd0);
        q.delete();
        m_icount = 16'd0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);

        build(4'h1, 2, 0, 1'b0);
        play(1000);
        build(4'hF, 0, 0, 1'b0);
        chk("halt_len", 32'(q.size()), 32'd2);
        play(1000);
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            mem_ready = 1'($urandom);
            #1;
            chk("halt_state", 32'(state), 32'd6);
            chk("halt_strobes", 32'(strobes()), 32'(HLT));
            chk("halt_icount", 32'(icount), 32'd2);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_icount", 32'(icount), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the CPU datapath.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and drives the datapath strobes: PC, IR, ALU, register file and memory.
- Handshakes with the unified memory port.
- Sits between the instruction register/opcode decode and the datapath; the existing control block supplies the per-opcode ALU function, and this block supplies the timing.

Parameters:
- OPCODE_W, 4, opcode field width; opcodes are decoded per the Behaviour section.
- ICOUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; leaves IDLE when high.
- opcode  in  OPCODE_W  opcode field of the IR; valid from DECODE onward.
- zero_flag  in  1  ALU zero flag, sampled in EXECUTE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, qualified by mem_req.
- addr_sel  out  1  0 = PC drives the address, 1 = ALU result drives it.
- ir_load  out  1  IR captures memory read data.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= jump target; takes priority over pc_inc.
- alu_en  out  1  ALU result register captures.
- reg_we  out  1  register-file write.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- halted  out  1  high in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  3  current state encoding, for debug.
- icount  out  ICOUNT_W  retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (async, rst_n low): state=IDLE, icount=0, illegal=0. All strobes are 0, and halted=0.
- Strobes are combinational decodes of the state register plus mem_ready/opcode/zero_flag. state, icount and illegal are registered.
- IDLE: all strobes 0. Goes to FETCH on the next edge when run=1.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_load=1 and pc_inc=1 in that same cycle, then go to DECODE.
- DECODE: no strobes; one cycle. Next state by opcode:
  - 0x0-0x7 ALU → EXEC
  - 0x8 LOAD → EXEC
  - 0x9 STORE → EXEC
  - 0xA JUMP → EXEC
  - 0xB BEQZ → EXEC
  - 0xE NOP → retire, then FETCH
  - 0xF HALT → retire, then HALT
  - 0xC, 0xD illegal → see Optional Feature.
- EXEC: alu_en=1 for one cycle. Then:
  - ALU → WB.
  - LOAD/STORE → MEM.
  - JUMP → pc_load=1, retire, FETCH.
  - BEQZ → pc_load=zero_flag, retire, FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE, 0 for LOAD.
  - Holds while mem_ready=0.
  - On mem_ready: STORE → retire, FETCH; LOAD → WB.
- WB: reg_we=1, wb_sel=1 for LOAD, 0 for ALU. Retire, then FETCH.
- Retire: icount increments on the transition edge out of the retiring state. It wraps from 2^ICOUNT_W-1 to 0 without a flag.
- HALT:
  - halted=1, all other strobes 0.
  - run is ignored; only rst_n leaves HALT.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect.
- mem_ready outside FETCH/MEM is ignored.
- mem_req stays asserted across wait cycles with a stable address select and stable mem_we.
- Reset mid-access: mem_req drops asynchronously with rst_n, and the pending access is abandoned; the memory side must tolerate this.
- Minimum cycles with zero-wait memory: ALU 4, LOAD 5, STORE 4, JUMP/BEQZ 3, NOP 2.

Optional Feature:
- Macro: CPU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal=1 and goes to HALT without retiring (icount unchanged). illegal stays set until reset.
- Undefined: illegal opcodes behave as NOP (retire, FETCH), and illegal is tied to 0.

Test Plan:
- Reset, run=0 for 5 cycles → state=0, all strobes 0. Then run=1, zero-wait memory, opcode=0x3 → states 1,2,3,5,1. ir_load and pc_inc pulse once in FETCH, reg_we=1 and wb_sel=0 in WB, icount=1.
- LOAD (0x8) with mem_ready held low 3 cycles in MEM → mem_req=1, addr_sel=1, mem_we=0 stable for 4 cycles. Then WB with wb_sel=1, and icount increments by 1.
- BEQZ (0xB): with zero_flag=1, pc_load=1 in EXEC; with zero_flag=0, pc_load=0. Both cases return to FETCH after 3 cycles.
- HALT (0xF) → halted=1 and icount incremented. run toggling for 10 cycles gives no change. rst_n low returns to IDLE with icount=0.
- Opcode 0xC:
  - With CPU_SEQ_ILLEGAL_TRAP_EN: HALT, illegal=1, icount unchanged.
  - Without it: NOP, icount+1.
- Preload 0xFFFE retirements (force or run), then retire 2 more → icount reads 0xFFFF, then 0x0000. Also assert rst_n low during a MEM wait → mem_req=0 immediately and state=0.
